fifo_control: RTL

FIFO_CONTROL -- requirements
Module: fifo_control

---
 rtl/fifo_control.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_control.sv
// rtl/fifo_control.sv - Pointer, occupancy and status control for an 8-deep single-clock FIFO
//
// Drives an external 8-word synchronous memory.
// The memory returns read data one cycle after the read strobe.
//
// Parameters
//   BITNUMBER  data word width
//   LENGTH     memory depth in words (pointers are 3 bits)
//   AF_THRESH  almost_full when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-low
//   push          upstream write request
//   push_data     upstream write word
//   pop           downstream read request
//   mem_rdata     memory data_out
//   write         memory write strobe (combinational)
//   read          memory read strobe (combinational)
//   ptr_write     memory write address
//   ptr_read      memory read address
//   mem_wdata     memory data_in (passthrough of push_data)
//   pop_data      read word, zero unless pop_valid
//   pop_valid     pop_data valid, one cycle after read
//   count         occupancy 0..8
//   full          status flag
//   empty         status flag
//   almost_full   status flag
//   almost_empty  status flag
//   overflow      sticky error flag: push seen while full
//   underflow     sticky error flag: pop seen while empty
module fifo_control #(
    parameter int BITNUMBER = 10,
    parameter int LENGTH    = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [BITNUMBER-1:0] push_data,
    input  logic                 pop,
    input  logic [BITNUMBER-1:0] mem_rdata,
    output logic                 write,
    output logic                 read,
    output logic [2:0]           ptr_write,
    output logic [2:0]           ptr_read,
    output logic [BITNUMBER-1:0] mem_wdata,
    output logic [BITNUMBER-1:0] pop_data,
    output logic                 pop_valid,
    output logic [3:0]           count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic [3:0] DEPTH  = 4'(LENGTH);
    localparam logic [3:0] AF_LVL = 4'(AF_THRESH);
    localparam logic [3:0] AE_LVL = 4'(AE_THRESH);

    state_t     state;
    state_t     state_next;
    logic [3:0] count_next;

    // Strobes are gated by reset so the memory is never touched while reset is held.
    assign write     = push & ~full & reset;
    assign read      = pop & ~empty & reset;
    assign mem_wdata = push_data;

    assign empty        = (state == ST_EMPTY);
    assign full         = (state == ST_FULL);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign pop_data = pop_valid ? mem_rdata : '0;

    always_comb begin
        count_next = count;
        case ({write, read})
            2'b10:   count_next = count + 4'd1;
            2'b01:   count_next = count - 4'd1;
            default: count_next = count;
        endcase
    end

    // Only a lone write or lone read moves the state out of PARTIAL; a
    // simultaneous write and read leaves occupancy unchanged.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (write) state_next = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (write && !read && count_next == DEPTH)
                    state_next = ST_FULL;
                else if (read && !write && count_next == 4'd0)
                    state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (read) state_next = ST_PARTIAL;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_EMPTY;
            count     <= 4'd0;
            ptr_write <= 3'd0;
            ptr_read  <= 3'd0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            // 3-bit pointers wrap 7 -> 0 naturally.
            if (write) ptr_write <= ptr_write + 3'd1;
            if (read)  ptr_read  <= ptr_read + 3'd1;
            pop_valid <= read;
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & empty);
        end
    end

endmodule
